lru_matrix_tracker: RTL and testbench

- Per-set true-LRU tracker for an N-way set-associative cache.
- Stores a pairwise-order bit vector of WAYS*(WAYS-1)/2 bits for each of SETS sets.
- Accepts query, touch, demote and allocate operations through a valid/ready request port, and returns the victim way two cycles later.
- Sits beside the tag array in the cache controller and generalises the fixed 4-way, 6-bit pairwise LRU scheme to any way count and set count.

---
 rtl/lru_matrix_tracker_pkg.sv | 33 +++
 rtl/lru_matrix_tracker_if.sv | 43 ++++
 rtl/lru_matrix_update.sv | 73 +++++++
 rtl/lru_matrix_tracker.sv | 137 +++++++++++++
 tb/tb_lru_matrix_tracker.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lru_matrix_tracker_pkg.sv
// -----------------------------------------------------------------------------
// lru_pkg
// Shared types and helpers for the pairwise-order (matrix) LRU tracker.
//   lru_op_e  : request operation encoding (QUERY/TOUCH/DEMOTE/ALLOC)
//   lru_fsm_e : tracker FSM state, exported for debug observation
//   num_pairs : number of order bits per set for a given way count
//   pair_idx  : bit position of pair (i,j), i<j, in the per-set vector
// -----------------------------------------------------------------------------
package lru_pkg;

    typedef enum logic [1:0] {
        LRU_QUERY  = 2'd0,
        LRU_TOUCH  = 2'd1,
        LRU_DEMOTE = 2'd2,
        LRU_ALLOC  = 2'd3
    } lru_op_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } lru_fsm_e;

    function automatic int num_pairs(input int ways);
        return (ways * (ways - 1)) / 2;
    endfunction

    // Pairs are laid out row by row: (0,1),(0,2)..(0,N-1),(1,2),...
    // Row i starts after sum_{r<i}(N-1-r) = i*N - i*(i+1)/2 entries.
    function automatic int pair_idx(input int i, input int j, input int ways);
        return (i * ways) - ((i * (i + 1)) / 2) + (j - i - 1);
    endfunction

endpackage

// File: rtl/lru_matrix_tracker_if.sv
// -----------------------------------------------------------------------------
// lru_matrix_tracker_if
// Request/response bundle of the LRU tracker.
//   req_valid/req_ready : request handshake; a request transfers on any cycle
//                         where both are high. The requester may change
//                         req_* freely while req_valid is low.
//   req_op/req_set/req_way : operation, set index, way operand
//   rsp_valid           : one-cycle pulse, two cycles after the accept; no
//                         backpressure
//   rsp_victim/rsp_way  : LRU way before the update / way actually updated
//   dbg_state           : tracker FSM state, for observation only
// master = requester, slave = tracker.
// -----------------------------------------------------------------------------
interface lru_matrix_tracker_if #(
    parameter int WAYS = 4,
    parameter int SETS = 64
) ();
    import lru_pkg::*;

    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);

    logic             req_valid;
    logic             req_ready;
    lru_op_e          req_op;
    logic [SET_W-1:0] req_set;
    logic [WAY_W-1:0] req_way;
    logic             rsp_valid;
    logic [WAY_W-1:0] rsp_victim;
    logic [WAY_W-1:0] rsp_way;
    lru_fsm_e         dbg_state;

    modport master (
        output req_valid, req_op, req_set, req_way,
        input  req_ready, rsp_valid, rsp_victim, rsp_way, dbg_state
    );

    modport slave (
        input  req_valid, req_op, req_set, req_way,
        output req_ready, rsp_valid, rsp_victim, rsp_way, dbg_state
    );

endinterface

// File: rtl/lru_matrix_update.sv
// -----------------------------------------------------------------------------
// lru_matrix_update
// Combinational core of the tracker: victim selection and next-state update
// for one set's pairwise-order vector.
//   i_state      : current order bits, b(i,j)=1 means way i newer than way j
//   i_op         : operation
//   i_way        : way operand (unused for QUERY/ALLOC victim choice)
//   o_victim     : LRU way of i_state (lowest candidate, 0 if none)
//   o_next_state : order bits after the operation
//   o_eff_way    : way that was made MRU/LRU (victim for ALLOC)
// -----------------------------------------------------------------------------
module lru_matrix_update
    import lru_pkg::*;
#(
    parameter  int WAYS  = 4,
    localparam int WAY_W = $clog2(WAYS),
    localparam int PAIRS = num_pairs(WAYS)
) (
    input  logic [PAIRS-1:0] i_state,
    input  lru_op_e          i_op,
    input  logic [WAY_W-1:0] i_way,
    output logic [WAY_W-1:0] o_victim,
    output logic [PAIRS-1:0] o_next_state,
    output logic [WAY_W-1:0] o_eff_way
);

    logic [WAYS-1:0]  w_cand;
    logic [WAY_W-1:0] w_eff;
    logic             w_upd;
    logic             w_mru;

    // Way k is LRU when every other way is newer than it.
    for (genvar k = 0; k < WAYS; k++) begin : g_cand
        logic [WAYS-1:0] w_older;
        for (genvar m = 0; m < WAYS; m++) begin : g_m
            if (m > k) begin : g_hi
                assign w_older[m] = ~i_state[pair_idx(k, m, WAYS)];
            end else if (m < k) begin : g_lo
                assign w_older[m] = i_state[pair_idx(m, k, WAYS)];
            end else begin : g_self
                assign w_older[m] = 1'b1;
            end
        end
        assign w_cand[k] = &w_older;
    end

    // Descending scan so the lowest-index candidate wins on corrupt state.
    always_comb begin
        o_victim = '0;
        for (int k = WAYS - 1; k >= 0; k--) begin
            if (w_cand[k]) begin
                o_victim = WAY_W'(k);
            end
        end
    end

    assign w_eff     = (i_op == LRU_ALLOC) ? o_victim : i_way;
    assign w_upd     = (i_op != LRU_QUERY);
    assign w_mru     = (i_op != LRU_DEMOTE);
    assign o_eff_way = w_eff;

    // Row bits of the target way take w_mru, column bits take its inverse.
    for (genvar i = 0; i < WAYS; i++) begin : g_row
        for (genvar j = i + 1; j < WAYS; j++) begin : g_col
            localparam int P = pair_idx(i, j, WAYS);
            assign o_next_state[P] = !w_upd                  ? i_state[P] :
                                     (w_eff == WAY_W'(i))    ? w_mru      :
                                     (w_eff == WAY_W'(j))    ? ~w_mru     :
                                                               i_state[P];
        end
    end

endmodule

// File: rtl/lru_matrix_tracker.sv
// -----------------------------------------------------------------------------
// lru_matrix_tracker
// Per-set true-LRU tracker using pairwise-order bits, two-stage pipeline.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : lru_matrix_tracker_if.slave (request/response, debug state)
// Stage 1 (accept): capture op/set/way and the set's state, forwarding the
// stage-2 next state when both stages address the same set. Stage 2: compute
// victim and next state, write the set back, register the response.
// After reset an INIT sweep clears one set per cycle before accepting work.
// -----------------------------------------------------------------------------
module lru_matrix_tracker
    import lru_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 64
) (
    input logic                 clk,
    input logic                 rst_n,
    lru_matrix_tracker_if.slave bus
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);
    localparam int PAIRS = num_pairs(WAYS);

    logic [PAIRS-1:0] r_mem [SETS];

    lru_fsm_e         r_fsm;
    logic [SET_W-1:0] r_init_cnt;
    logic             r_req_ready;

    logic             r_s2_valid;
    lru_op_e          r_s2_op;
    logic [SET_W-1:0] r_s2_set;
    logic [WAY_W-1:0] r_s2_way;
    logic [PAIRS-1:0] r_s2_state;

    logic             r_rsp_valid;
    logic [WAY_W-1:0] r_rsp_victim;
    logic [WAY_W-1:0] r_rsp_way;

    logic             w_accept;
    logic             w_fwd;
    logic [PAIRS-1:0] w_rd_state;
    logic [WAY_W-1:0] w_victim;
    logic [PAIRS-1:0] w_next_state;
    logic [WAY_W-1:0] w_eff_way;

    assign w_accept   = bus.req_valid && r_req_ready;
    // Stage 2 writes at the same edge stage 1 captures, so take its result.
    assign w_fwd      = r_s2_valid && (r_s2_set == bus.req_set);
    assign w_rd_state = w_fwd ? w_next_state : r_mem[bus.req_set];

    lru_matrix_update #(
        .WAYS (WAYS)
    ) u_update (
        .i_state      (r_s2_state),
        .i_op         (r_s2_op),
        .i_way        (r_s2_way),
        .o_victim     (w_victim),
        .o_next_state (w_next_state),
        .o_eff_way    (w_eff_way)
    );

    // Control FSM: INIT sweeps all sets, RUN accepts requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm       <= ST_INIT;
            r_init_cnt  <= '0;
            r_req_ready <= 1'b0;
        end else begin
            case (r_fsm)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == SET_W'(SETS - 1)) begin
                        r_fsm       <= ST_RUN;
                        r_req_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_fsm       <= ST_INIT;
                    r_init_cnt  <= '0;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    // State storage: cleared by the sweep, updated by stage 2. Writes are
    // suppressed under reset so a dropped request leaves no trace.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_fsm == ST_INIT) begin
                r_mem[r_init_cnt] <= '0;
            end else if (r_s2_valid) begin
                r_mem[r_s2_set] <= w_next_state;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_s2_op      <= LRU_QUERY;
            r_s2_set     <= '0;
            r_s2_way     <= '0;
            r_s2_state   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_victim <= '0;
            r_rsp_way    <= '0;
        end else begin
            r_s2_valid <= w_accept;
            if (w_accept) begin
                r_s2_op    <= bus.req_op;
                r_s2_set   <= bus.req_set;
                r_s2_way   <= bus.req_way;
                r_s2_state <= w_rd_state;
            end
            r_rsp_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_rsp_victim <= w_victim;
                r_rsp_way    <= w_eff_way;
            end
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_victim = r_rsp_victim;
    assign bus.rsp_way    = r_rsp_way;
    assign bus.dbg_state  = r_fsm;

endmodule

// File: tb/tb_lru_matrix_tracker.sv
// -----------------------------------------------------------------------------
// tb_lru_matrix_tracker
// Directed bench for a 4-way/64-set tracker with hand-computed responses,
// plus a random stream on an 8-way/16-set tracker checked against an
// age-list reference (position 0 = MRU, position 7 = LRU).
// -----------------------------------------------------------------------------
module tb_lru_matrix_tracker;
    import lru_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lru_matrix_tracker_if #(.WAYS(4), .SETS(64)) bus4 ();
    lru_matrix_tracker_if #(.WAYS(8), .SETS(16)) bus8 ();

    lru_matrix_tracker #(.WAYS(4), .SETS(64)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    lru_matrix_tracker #(.WAYS(8), .SETS(16)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    int checks = 0;
    int errors = 0;

    // Two-deep pipe of expected responses per DUT: [dut][age]
    int pv   [2][2];
    int pvic [2][2];
    int pway [2][2];

    int age [16][8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_pipes();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 2; a++) begin
                pv[d][a] = 0; pvic[d][a] = 0; pway[d][a] = 0;
            end
        end
    endtask

    task automatic check_rsp(input int d);
        logic        rv;
        logic [31:0] vic;
        logic [31:0] wy;
        if (d == 0) begin
            rv = bus4.rsp_valid; vic = 32'(bus4.rsp_victim); wy = 32'(bus4.rsp_way);
        end else begin
            rv = bus8.rsp_valid; vic = 32'(bus8.rsp_victim); wy = 32'(bus8.rsp_way);
        end
        chk((d == 0) ? "rsp_valid4" : "rsp_valid8", 32'(rv), pv[d][1]);
        if (pv[d][1] != 0) begin
            chk((d == 0) ? "rsp_victim4" : "rsp_victim8", vic, pvic[d][1]);
            chk((d == 0) ? "rsp_way4" : "rsp_way8", wy, pway[d][1]);
        end
    endtask

    // Called at a negedge: checks the response of the request issued two
    // calls earlier, then drives this call's request for one cycle.
    task automatic step(input int d, input bit v, input lru_op_e op,
                        input int set, input int way, input int ev, input int ew);
        check_rsp(d);
        pv[d][1] = pv[d][0]; pvic[d][1] = pvic[d][0]; pway[d][1] = pway[d][0];
        pv[d][0] = v ? 1 : 0; pvic[d][0] = ev; pway[d][0] = ew;
        if (d == 0) begin
            bus4.req_valid = v; bus4.req_op = op;
            bus4.req_set = 6'(set); bus4.req_way = 2'(way);
        end else begin
            bus8.req_valid = v; bus8.req_op = op;
            bus8.req_set = 4'(set); bus8.req_way = 3'(way);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int d, input int n);
        for (int k = 0; k < n; k++) step(d, 1'b0, LRU_QUERY, 0, 0, 0, 0);
    endtask

    // Counts negedge samples with req_ready low, starting at the release.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (bus4.req_ready !== 1'b1 && cnt < 200) begin
            cnt++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic move_front(input int s, input int w);
        int p;
        p = 0;
        for (int q = 0; q < 8; q++) if (age[s][q] == w) p = q;
        for (int q = p; q > 0; q--) age[s][q] = age[s][q-1];
        age[s][0] = w;
    endtask

    task automatic move_back(input int s, input int w);
        int p;
        p = 0;
        for (int q = 0; q < 8; q++) if (age[s][q] == w) p = q;
        for (int q = p; q < 7; q++) age[s][q] = age[s][q+1];
        age[s][7] = w;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit v;
        lru_op_e op;
        int s, w, ev, ew;

        rst_n = 1'b0;
        bus4.req_valid = 1'b0; bus4.req_op = LRU_QUERY; bus4.req_set = '0; bus4.req_way = '0;
        bus8.req_valid = 1'b0; bus8.req_op = LRU_QUERY; bus8.req_set = '0; bus8.req_way = '0;
        clear_pipes();
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset values
        chk("rst_ready", 32'(bus4.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus4.rsp_valid), 0);
        chk("rst_rsp_victim", 32'(bus4.rsp_victim), 0);
        chk("rst_rsp_way", 32'(bus4.rsp_way), 0);
        chk("rst_state", 32'(bus4.dbg_state), 32'(ST_INIT));

        // INIT lasts exactly SETS cycles
        rst_n = 1'b1;
        wait_ready(cnt);
        chk("init_cycles", cnt, 64);
        chk("run_state", 32'(bus4.dbg_state), 32'(ST_RUN));
        chk("ready8", 32'(bus8.req_ready), 1);

        // Fresh sets report victim 0; QUERY echoes req_way
        step(0, 1'b1, LRU_QUERY, 17, 0, 0, 0);
        step(0, 1'b1, LRU_QUERY, 63, 3, 0, 3);
        idle(0, 2);

        // Set 5: touch 0,1,2 -> LRU 3; touch 3 -> LRU 0
        step(0, 1'b1, LRU_TOUCH, 5, 0, 0, 0);
        step(0, 1'b1, LRU_TOUCH, 5, 1, 1, 1);
        step(0, 1'b1, LRU_TOUCH, 5, 2, 2, 2);
        step(0, 1'b1, LRU_QUERY, 5, 0, 3, 0);
        step(0, 1'b1, LRU_TOUCH, 5, 3, 3, 3);
        step(0, 1'b1, LRU_QUERY, 5, 1, 0, 1);
        idle(0, 2);

        // Set 9: back-to-back ALLOCs cycle through the ways (forwarding)
        step(0, 1'b1, LRU_ALLOC, 9, 2, 0, 0);
        step(0, 1'b1, LRU_ALLOC, 9, 2, 1, 1);
        step(0, 1'b1, LRU_ALLOC, 9, 2, 2, 2);
        step(0, 1'b1, LRU_ALLOC, 9, 2, 3, 3);
        step(0, 1'b1, LRU_ALLOC, 9, 2, 0, 0);
        idle(0, 2);

        // Set 3 with set 4 traffic interleaved
        step(0, 1'b1, LRU_TOUCH, 3, 0, 0, 0);
        step(0, 1'b1, LRU_TOUCH, 4, 1, 0, 1);
        step(0, 1'b1, LRU_TOUCH, 3, 1, 1, 1);
        step(0, 1'b1, LRU_ALLOC, 4, 3, 0, 0);
        step(0, 1'b1, LRU_TOUCH, 3, 2, 2, 2);
        step(0, 1'b1, LRU_TOUCH, 3, 3, 3, 3);
        step(0, 1'b1, LRU_DEMOTE, 3, 2, 0, 2);
        step(0, 1'b1, LRU_TOUCH, 4, 0, 2, 0);
        step(0, 1'b1, LRU_QUERY, 3, 0, 2, 0);
        step(0, 1'b1, LRU_QUERY, 4, 0, 2, 0);
        idle(0, 2);

        // Reset while a TOUCH is in stage 2: no response appears
        bus4.req_valid = 1'b1; bus4.req_op = LRU_TOUCH; bus4.req_set = 6'd7; bus4.req_way = 2'd1;
        @(posedge clk);
        @(negedge clk);
        bus4.req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("flush_rsp_valid", 32'(bus4.rsp_valid), 0);
        chk("flush_ready", 32'(bus4.req_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("flush_rsp_valid2", 32'(bus4.rsp_valid), 0);

        // Reset mid-INIT restarts the sweep
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("mid_init_ready", 32'(bus4.req_ready), 0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(cnt);
        chk("reinit_cycles", cnt, 64);
        clear_pipes();

        step(0, 1'b1, LRU_QUERY, 7, 0, 0, 0);
        step(0, 1'b1, LRU_QUERY, 5, 0, 0, 0);
        idle(0, 2);

        // Random stream on the 8-way tracker against the age-list model
        for (int si = 0; si < 16; si++) begin
            for (int p = 0; p < 8; p++) age[si][p] = 7 - p;
        end
        for (int n = 0; n < 400; n++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = lru_op_e'($urandom_range(0, 3));
            s  = $urandom_range(0, 15);
            w  = $urandom_range(0, 7);
            ev = 0;
            ew = 0;
            if (v) begin
                ev = age[s][7];
                ew = (op == LRU_ALLOC) ? ev : w;
                if (op == LRU_TOUCH || op == LRU_ALLOC) move_front(s, ew);
                else if (op == LRU_DEMOTE) move_back(s, ew);
            end
            step(1, v, op, s, w, ev, ew);
        end
        idle(1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
